// File: rtl/sigma_mem_pkg.sv
// Shared definitions for the memory-side arbiter: FSM state encoding,
// page geometry, byte-lane layout, master ids and a byte-merge helper.
package sigma_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CPU  = 2'd1,
      ST_IOP  = 2'd2,
      ST_TURN = 2'd3
   } arb_state_t;

   typedef enum logic {
      MASTER_CPU = 1'b0,
      MASTER_IOP = 1'b1
   } master_id_t;

   localparam int PAGE_WORDS = 512;
   localparam int PAGE_SHIFT = $clog2(PAGE_WORDS);
   localparam int BYTE_LANES = 4;
   localparam int BYTE_W     = 8;

   // Overlay the enabled byte lanes of wr onto base; lane 0 is bits [0:7].
   function automatic logic [0:31] merge_lanes(input logic [0:31] base,
                                               input logic [0:31] wr,
                                               input logic [0:3]  be);
      logic [0:31] r;
      r = base;
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (be[i]) r[i*BYTE_W +: BYTE_W] = wr[i*BYTE_W +: BYTE_W];
      end
      return r;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Shared memory bus as seen by the two masters and the memory-side arbiter.
interface mem_arbiter_if #(parameter int ADDR_W = 17);
   logic                 cpu_req;
   logic                 iop_req;
   logic                 cpu_grant;
   logic                 iop_active;
   logic [15:ADDR_W+14]  bus_address;
   logic [0:31]          bus_wdata;
   logic [0:3]           bus_wr_en;
   logic [0:31]          bus_rdata;

   modport slave (
      input  cpu_req, iop_req, bus_address, bus_wdata, bus_wr_en,
      output cpu_grant, iop_active, bus_rdata
   );

   modport master (
      output cpu_req, iop_req, bus_address, bus_wdata, bus_wr_en,
      input  cpu_grant, iop_active, bus_rdata
   );
endinterface

// File: rtl/mem_arb_fsm.sv
// Bus ownership FSM: round-robin between CPU and IOP with a tenure limit
// that only applies while the other master is waiting.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | nobody owns the bus, decide next owner
// ST_CPU  | CPU owns the bus (cpu_grant high)
// ST_IOP  | IOP owns the bus (iop_active high)
// ST_TURN | dead cycle for tri-state turnaround
module mem_arb_fsm
   import sigma_mem_pkg::*;
#(
   parameter int TENURE_MAX = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic cpu_req,
   input  logic iop_req,
   output logic cpu_grant,
   output logic iop_active
);

   localparam logic [7:0] TENURE_LIM = 8'(TENURE_MAX);

   arb_state_t state_q, state_d;
   logic [7:0] tenure_q, tenure_d;
   master_id_t last_q, last_d;

   // State, tenure and last-owner registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         tenure_q <= 8'd0;
         last_q   <= MASTER_IOP;
      end else begin
         state_q  <= state_d;
         tenure_q <= tenure_d;
         last_q   <= last_d;
      end
   end

   // Next-state decision; tenure counts granted cycles and saturates at the limit.
   always_comb begin
      state_d  = state_q;
      tenure_d = tenure_q;
      last_d   = last_q;
      case (state_q)
         ST_IDLE: begin
            tenure_d = 8'd0;
            if (cpu_req && (!iop_req || last_q == MASTER_IOP)) begin
               state_d  = ST_CPU;
               last_d   = MASTER_CPU;
               tenure_d = 8'd1;
            end else if (iop_req) begin
               state_d  = ST_IOP;
               last_d   = MASTER_IOP;
               tenure_d = 8'd1;
            end
         end
         ST_CPU: begin
            if (!cpu_req || (tenure_q == TENURE_LIM && iop_req)) begin
               state_d  = ST_TURN;
               tenure_d = 8'd0;
            end else if (tenure_q != TENURE_LIM) begin
               tenure_d = tenure_q + 8'd1;
            end
         end
         ST_IOP: begin
            if (!iop_req || (tenure_q == TENURE_LIM && cpu_req)) begin
               state_d  = ST_TURN;
               tenure_d = 8'd0;
            end else if (tenure_q != TENURE_LIM) begin
               tenure_d = tenure_q + 8'd1;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            tenure_d = 8'd0;
         end
      endcase
   end

   assign cpu_grant  = (state_q == ST_CPU);
   assign iop_active = (state_q == ST_IOP);

endmodule

// File: rtl/mem_arbiter.sv
// Memory-side responder for the shared word-addressed bus. Owns arbitration
// (via mem_arb_fsm), the request stage S1 that drives the RAM, and the read
// stage S2 with write-to-read forwarding.
// Optional feature: define MEM_WRPROTECT_EN for per-page IOP write locks.
module mem_arbiter
   import sigma_mem_pkg::*;
#(
   parameter int TENURE_MAX = 16,
   parameter int ADDR_W     = 17
) (
   input  logic                clock,
   input  logic                reset,
   mem_arbiter_if.slave        bus,
   output logic [15:ADDR_W+14] ram_addr,
   output logic [0:31]         ram_wdata,
   output logic [0:3]          ram_we,
   input  logic [0:31]         ram_rdata,
   output logic                prot_fault,
   input  logic                lock_we,
   input  logic [0:7]          lock_page,
   input  logic                lock_val
);

   logic granted;
   logic wr_blocked;

   mem_arb_fsm #(.TENURE_MAX(TENURE_MAX)) u_fsm (
      .clock      (clock),
      .reset      (reset),
      .cpu_req    (bus.cpu_req),
      .iop_req    (bus.iop_req),
      .cpu_grant  (bus.cpu_grant),
      .iop_active (bus.iop_active)
   );

   assign granted = bus.cpu_grant | bus.iop_active;

`ifdef MEM_WRPROTECT_EN
   logic [0:255] lock_q;
   logic [7:0]   page;
   logic         fault_q;

   assign page       = 8'(bus.bus_address >> PAGE_SHIFT);
   assign wr_blocked = bus.iop_active && (bus.bus_wr_en != 4'b0) && lock_q[page];

   // Page lock table, programmed one entry per edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)       lock_q <= '0;
      else if (lock_we) lock_q[lock_page] <= lock_val;
   end

   // Fault pulse lines up with the S1 cycle whose write was dropped.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fault_q <= 1'b0;
      else        fault_q <= wr_blocked;
   end

   assign prot_fault = fault_q;
`else
   logic unused_lock;
   assign unused_lock = ^{lock_we, lock_page, lock_val};
   assign wr_blocked  = 1'b0;
   assign prot_fault  = 1'b0;
`endif

   // S1: capture the owner's request; with no owner, hold address and read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_we    <= '0;
      end else if (granted) begin
         ram_addr  <= bus.bus_address;
         ram_wdata <= bus.bus_wdata;
         ram_we    <= wr_blocked ? 4'b0 : bus.bus_wr_en;
      end else begin
         ram_we    <= '0;
      end
   end

   logic [15:ADDR_W+14] d1_addr, d2_addr;
   logic [0:3]          d1_we, d2_we;
   logic [0:31]         d1_wdata, d2_wdata;
   logic [0:31]         rdata_q;
   logic                fwd;

   // Delay copies of S1: d1 matches the RAM output now, d2 is the access before it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d1_addr  <= '0;
         d1_we    <= '0;
         d1_wdata <= '0;
         d2_addr  <= '0;
         d2_we    <= '0;
         d2_wdata <= '0;
      end else begin
         d1_addr  <= ram_addr;
         d1_we    <= ram_we;
         d1_wdata <= ram_wdata;
         d2_addr  <= d1_addr;
         d2_we    <= d1_we;
         d2_wdata <= d1_wdata;
      end
   end

   assign fwd = (d2_we != 4'b0) && (d1_we == 4'b0) && (d2_addr == d1_addr);

   // S2: register read data, overlaying bytes from a write just ahead of it.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)   rdata_q <= '0;
      else if (fwd) rdata_q <= merge_lanes(ram_rdata, d2_wdata, d2_we);
      else          rdata_q <= ram_rdata;
   end

   assign bus.bus_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

   localparam int TENURE = 16;
`ifdef MEM_WRPROTECT_EN
   localparam bit WP = 1'b1;
`else
   localparam bit WP = 1'b0;
`endif

   typedef struct {
      int          due;
      logic [31:0] val;
   } rd_t;

   logic        clock = 1'b0;
   logic        reset;
   logic [15:31] ram_addr;
   logic [0:31] ram_wdata;
   logic [0:3]  ram_we;
   logic [0:31] ram_rdata = '0;
   logic        prot_fault;
   logic        lock_we, lock_val;
   logic [0:7]  lock_page;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;

   bit [31:0]   mem [0:131071];
   bit [31:0]   model [int];
   rd_t         pend [$];
   rd_t         r;
   logic [16:0] ra;
   logic [31:0] rd;
   logic [3:0]  rwe;
   logic [31:0] ram_word;

   mem_arbiter_if #(.ADDR_W(17)) bus_if ();

   mem_arbiter #(.TENURE_MAX(TENURE), .ADDR_W(17)) dut (
      .clock      (clock),
      .reset      (reset),
      .bus        (bus_if),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_we     (ram_we),
      .ram_rdata  (ram_rdata),
      .prot_fault (prot_fault),
      .lock_we    (lock_we),
      .lock_page  (lock_page),
      .lock_val   (lock_val)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] lane_mask(input int i);
      return 32'hFF00_0000 >> (8 * i);
   endfunction

   // Byte lane i is the i-th most significant byte; be[3-i] enables it.
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] v;
      v = old;
      for (int i = 0; i < 4; i++)
         if (be[3-i]) v = (v & ~lane_mask(i)) | (wd & lane_mask(i));
      return v;
   endfunction

   // Synchronous single-port RAM, one-cycle read latency, read-first.
   always @(posedge clock) begin
      ram_word = mem[ram_addr];
      ram_rdata <= ram_word;
      ram_word = merge(ram_word, ram_wdata, ram_we);
      mem[ram_addr] <= ram_word;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic creq, input logic ireq, input logic [16:0] a,
                        input logic [31:0] d, input logic [3:0] we);
      bus_if.cpu_req     = creq;
      bus_if.iop_req     = ireq;
      bus_if.bus_address = a;
      bus_if.bus_wdata   = d;
      bus_if.bus_wr_en   = we;
   endtask

   task automatic go_idle();
      drive(1'b0, 1'b0, 17'h0, 32'h0, 4'h0);
      repeat (3) step();
   endtask

   initial begin
      reset = 1'b1;
      lock_we = 1'b0; lock_page = 8'h0; lock_val = 1'b0;
      drive(1'b0, 1'b0, 17'h0, 32'h0, 4'h0);
      #1 reset = 1'b0;
      repeat (2) step();
      chk("rst_cpu_grant", bus_if.cpu_grant, 0);
      chk("rst_iop_active", bus_if.iop_active, 0);
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_addr", ram_addr, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_bus_rdata", bus_if.bus_rdata, 0);
      chk("rst_prot_fault", prot_fault, 0);
      reset = 1'b1;

      // IOP alone: write then read 0x2A
      drive(1'b0, 1'b1, 17'h2A, 32'h32100021, 4'hF);
      step();
      chk("iop_grant_lat", bus_if.iop_active, 1);
      chk("iop_no_cpu", bus_if.cpu_grant, 0);
      chk("iop_we_early", ram_we, 0);
      step();
      chk("iop_wr_we", ram_we, 4'hF);
      chk("iop_wr_addr", ram_addr, 17'h2A);
      chk("iop_wr_data", ram_wdata, 32'h32100021);
      drive(1'b0, 1'b1, 17'h2A, 32'h0, 4'h0);
      repeat (3) step();
      chk("iop_rd_data", bus_if.bus_rdata, 32'h32100021);

      // release and earliest re-grant
      bus_if.iop_req = 1'b0;
      step();
      chk("rel_drop", bus_if.iop_active, 0);
      bus_if.iop_req = 1'b1;
      step();
      chk("rel_turn", bus_if.iop_active, 0);
      step();
      chk("rel_regrant", bus_if.iop_active, 1);
      go_idle();

      // tie straight out of reset: CPU first
      reset = 1'b0;
      #2 reset = 1'b1;
      drive(1'b1, 1'b1, 17'h40, 32'h0, 4'h0);
      step();
      chk("tie_cpu", bus_if.cpu_grant, 1);
      chk("tie_iop_wait", bus_if.iop_active, 0);
      repeat (3) step();
      chk("tie_hold", bus_if.cpu_grant, 1);
      bus_if.cpu_req = 1'b0;
      step();
      chk("tie_rel", bus_if.cpu_grant, 0);
      step();
      chk("tie_turn", bus_if.iop_active, 0);
      step();
      chk("tie_iop", bus_if.iop_active, 1);

      // uncontended tenure is unlimited, then saturated counter preempts at once
      repeat (TENURE + 4) step();
      chk("sat_hold", bus_if.iop_active, 1);
      bus_if.cpu_req = 1'b1;
      step();
      chk("sat_preempt", bus_if.iop_active, 0);
      step();
      step();
      chk("rr_cpu", bus_if.cpu_grant, 1);

      // contended CPU tenure lasts exactly TENURE cycles
      for (int k = 2; k <= TENURE; k++) begin
         step();
         chk("pre_tenure", bus_if.cpu_grant, 1);
      end
      step();
      chk("pre_drop", bus_if.cpu_grant, 0);
      step();
      chk("pre_turn", bus_if.iop_active, 0);
      step();
      chk("pre_iop", bus_if.iop_active, 1);
      go_idle();

      // forwarding of a partial write into the following read
      mem[17'h100] = 32'h11223344;
      drive(1'b1, 1'b0, 17'h100, 32'hAABBCCDD, 4'h3);
      step();
      step();
      chk("fwd_we", ram_we, 4'h3);
      drive(1'b1, 1'b0, 17'h100, 32'h0, 4'h0);
      repeat (3) step();
      chk("fwd_rdata", bus_if.bus_rdata, 32'h1122CCDD);
      go_idle();

      // random reads/writes against a word-level memory model
      for (int a = 0; a < 16; a++) begin
         rd = $urandom;
         mem[17'h300 + a] = rd;
         model[32'h300 + a] = rd;
      end
      drive(1'b0, 1'b1, 17'h300, 32'h0, 4'h0);
      step();
      for (int c = 0; c < 200; c++) begin
         ra  = 17'h300 + 17'($urandom_range(0, 15));
         rd  = $urandom;
         rwe = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
         drive(1'b0, 1'b1, ra, rd, rwe);
         step();
         cyc++;
         if (rwe == 4'h0) begin
            r.due = cyc + 2;
            r.val = model[int'(ra)];
            pend.push_back(r);
         end else begin
            model[int'(ra)] = merge(model[int'(ra)], rd, rwe);
         end
         while (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rand_rd", bus_if.bus_rdata, pend[0].val);
            void'(pend.pop_front());
         end
      end
      drive(1'b0, 1'b1, 17'h300, 32'h0, 4'h0);
      repeat (2) begin
         step();
         cyc++;
         while (pend.size() > 0 && pend[0].due == cyc) begin
            chk("rand_rd", bus_if.bus_rdata, pend[0].val);
            void'(pend.pop_front());
         end
      end
      go_idle();

      // asynchronous reset while a write sits in S1
      drive(1'b1, 1'b0, 17'h50, 32'hDEADBEEF, 4'hF);
      step();
      step();
      chk("rm_we_before", ram_we, 4'hF);
      #2 reset = 1'b0;
      #1;
      chk("rm_cpu_grant", bus_if.cpu_grant, 0);
      chk("rm_ram_we", ram_we, 0);
      chk("rm_ram_addr", ram_addr, 0);
      chk("rm_ram_wdata", ram_wdata, 0);
      chk("rm_bus_rdata", bus_if.bus_rdata, 0);
      drive(1'b0, 1'b0, 17'h0, 32'h0, 4'h0);
      step();
      reset = 1'b1;
      repeat (2) step();
      chk("rm_mem_untouched", mem[17'h50], 32'h0);

      // write protection on page 0
      lock_we = 1'b1; lock_page = 8'h00; lock_val = 1'b1;
      step();
      lock_we = 1'b0;
      drive(1'b0, 1'b1, 17'h21, 32'h5A5A5A5A, 4'hF);
      step();
      chk("wp_fault_idle", prot_fault, 0);
      step();
      chk("wp_iop_we", ram_we, WP ? 4'h0 : 4'hF);
      chk("wp_fault", prot_fault, WP ? 1 : 0);
      drive(1'b0, 1'b1, 17'h21, 32'h0, 4'h0);
      step();
      chk("wp_fault_once", prot_fault, 0);
      chk("wp_iop_mem", mem[17'h21], WP ? 32'h0 : 32'h5A5A5A5A);
      go_idle();
      drive(1'b1, 1'b0, 17'h21, 32'hC3C3C3C3, 4'hF);
      step();
      step();
      chk("wp_cpu_we", ram_we, 4'hF);
      step();
      chk("wp_cpu_mem", mem[17'h21], 32'hC3C3C3C3);
      chk("wp_cpu_fault", prot_fault, 0);
      go_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
